game_move_sequencer: RTL and testbench

GAME_MOVE_SEQUENCER -- requirements
Module: game_move_sequencer

---
 rtl/game_move_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_game_move_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_move_sequencer.sv
// game_move_sequencer: control FSM for a 4x4 sliding-tile game.
// Each move runs an external movement pass, an external summation pass and a
// second movement pass. If the board changed, the result is committed, checked
// for a winning tile, a new tile is spawned at a pseudo-random empty cell, and
// the board is checked for a lost position. After reset the board is seeded
// with two spawned tiles.
//
// Optional feature macro: SPAWN_FOUR_EN
//   defined   - a spawned tile is 4 when lfsr[6:4]==0, otherwise 2
//   undefined - a spawned tile is always 2
//
// Ports
//   clk          system clock, all state on rising edge
//   rst          asynchronous active-high reset
//   dir          one-hot move request (1000 left, 0100 down, 0010 up, 0001 right)
//   board        committed board, board[row][col] is a 12-bit tile value
//   move_dir     latched direction for the datapaths
//   work_matrix  operand for the datapaths (the work register)
//   mov_en       movement request; mov_done/mov_result complete it
//   sum_en       summation request; sum_ready/sum_result complete it
//   busy         high except in IDLE, WIN and LOSE
//   game_won     high in the terminal WIN state
//   game_lost    high in the terminal LOSE state
module game_move_sequencer #(
    parameter logic [11:0] WIN_VALUE = 12'd2048,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             dir,
    output logic [3:0][3:0][11:0]  board,
    output logic [3:0]             move_dir,
    output logic [3:0][3:0][11:0]  work_matrix,
    output logic                   mov_en,
    input  logic                   mov_done,
    input  logic [3:0][3:0][11:0]  mov_result,
    output logic                   sum_en,
    input  logic                   sum_ready,
    input  logic [3:0][3:0][11:0]  sum_result,
    output logic                   busy,
    output logic                   game_won,
    output logic                   game_lost
);

    localparam int unsigned TILE_W = 12;
    localparam int unsigned ST_W   = 4;

    localparam logic [ST_W-1:0] INIT  = 4'd0;
    localparam logic [ST_W-1:0] IDLE  = 4'd1;
    localparam logic [ST_W-1:0] MOVE1 = 4'd2;
    localparam logic [ST_W-1:0] SUM   = 4'd3;
    localparam logic [ST_W-1:0] MOVE2 = 4'd4;
    localparam logic [ST_W-1:0] CHECK = 4'd5;
    localparam logic [ST_W-1:0] SPAWN = 4'd6;
    localparam logic [ST_W-1:0] EVAL  = 4'd7;
    localparam logic [ST_W-1:0] WIN   = 4'd8;
    localparam logic [ST_W-1:0] LOSE  = 4'd9;

    logic [ST_W-1:0]              state, state_nxt;
    logic [3:0][3:0][TILE_W-1:0]  board_nxt, work_nxt;
    logic [3:0]                   move_dir_nxt;
    logic [3:0]                   idx, idx_nxt;
    logic [3:0]                   scan_cnt, scan_nxt;
    logic [1:0]                   init_cnt, init_nxt;
    logic [15:0]                  lfsr;
    logic                         spawn_done;
    logic                         dir_onehot;
    logic                         board_has_zero;
    logic                         board_has_pair;
    logic                         work_has_win;
    logic [TILE_W-1:0]            spawn_val;
    logic                         busy_nxt, mov_en_nxt, sum_en_nxt;
    logic                         won_nxt, lost_nxt;

    // Spawn tile value
`ifdef SPAWN_FOUR_EN
    assign spawn_val = (lfsr[6:4] == 3'b000) ? TILE_W'(4) : TILE_W'(2);
`else
    assign spawn_val = TILE_W'(2);
`endif

    // Exactly one direction bit set
    assign dir_onehot = (dir != 4'b0000) && ((dir & (dir - 4'd1)) == 4'b0000);

    // Fibonacci LFSR, taps 16,14,13,11, free-running outside reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Board status: any empty cell, any equal orthogonal neighbours
    always_comb begin
        board_has_zero = 1'b0;
        board_has_pair = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board[r][c] == '0) begin
                    board_has_zero = 1'b1;
                end
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (board[r][c] == board[r][c+1]) begin
                    board_has_pair = 1'b1;
                end
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board[r][c] == board[r+1][c]) begin
                    board_has_pair = 1'b1;
                end
            end
        end
    end

    // Winning tile present in the work register
    always_comb begin
        work_has_win = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (work_matrix[r][c] >= WIN_VALUE) begin
                    work_has_win = 1'b1;
                end
            end
        end
    end

    // Next-state and datapath-register next values
    always_comb begin
        state_nxt    = state;
        board_nxt    = board;
        work_nxt     = work_matrix;
        move_dir_nxt = move_dir;
        idx_nxt      = idx;
        scan_nxt     = scan_cnt;
        init_nxt     = init_cnt;
        spawn_done   = 1'b0;

        case (state)
            INIT: begin
                idx_nxt   = lfsr[3:0];
                scan_nxt  = '0;
                state_nxt = SPAWN;
            end
            IDLE: begin
                if (dir_onehot) begin
                    move_dir_nxt = dir;
                    work_nxt     = board;
                    state_nxt    = MOVE1;
                end
            end
            MOVE1: begin
                if (mov_done) begin
                    work_nxt  = mov_result;
                    state_nxt = SUM;
                end
            end
            SUM: begin
                if (sum_ready) begin
                    work_nxt  = sum_result;
                    state_nxt = MOVE2;
                end
            end
            MOVE2: begin
                if (mov_done) begin
                    work_nxt  = mov_result;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (work_matrix == board) begin
                    state_nxt = IDLE;
                end else begin
                    board_nxt = work_matrix;
                    if (work_has_win) begin
                        state_nxt = WIN;
                    end else begin
                        idx_nxt   = lfsr[3:0];
                        scan_nxt  = '0;
                        state_nxt = SPAWN;
                    end
                end
            end
            SPAWN: begin
                // One cell per cycle; give up after all 16 were examined
                if (board[idx[3:2]][idx[1:0]] == '0) begin
                    board_nxt[idx[3:2]][idx[1:0]] = spawn_val;
                    spawn_done = 1'b1;
                end else begin
                    idx_nxt  = idx + 4'd1;
                    scan_nxt = scan_cnt + 4'd1;
                    if (scan_cnt == 4'd15) begin
                        spawn_done = 1'b1;
                    end
                end
                // init_cnt: 0 = first seed tile, 1 = second seed tile, 2 = play
                if (spawn_done) begin
                    case (init_cnt)
                        2'd0: begin
                            init_nxt  = 2'd1;
                            state_nxt = INIT;
                        end
                        2'd1: begin
                            init_nxt  = 2'd2;
                            state_nxt = IDLE;
                        end
                        default: begin
                            state_nxt = EVAL;
                        end
                    endcase
                end
            end
            EVAL: begin
                if (!board_has_zero && !board_has_pair) begin
                    state_nxt = LOSE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WIN:  state_nxt = WIN;
            LOSE: state_nxt = LOSE;
            default: state_nxt = INIT;
        endcase
    end

    // Registered outputs decoded from the next state
    always_comb begin
        busy_nxt   = !((state_nxt == IDLE) || (state_nxt == WIN) || (state_nxt == LOSE));
        mov_en_nxt = (state_nxt == MOVE1) || (state_nxt == MOVE2);
        sum_en_nxt = (state_nxt == SUM);
        won_nxt    = (state_nxt == WIN);
        lost_nxt   = (state_nxt == LOSE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            board       <= '0;
            work_matrix <= '0;
            move_dir    <= 4'b0000;
            idx         <= '0;
            scan_cnt    <= '0;
            init_cnt    <= 2'd0;
            busy        <= 1'b1;
            mov_en      <= 1'b0;
            sum_en      <= 1'b0;
            game_won    <= 1'b0;
            game_lost   <= 1'b0;
        end else begin
            state       <= state_nxt;
            board       <= board_nxt;
            work_matrix <= work_nxt;
            move_dir    <= move_dir_nxt;
            idx         <= idx_nxt;
            scan_cnt    <= scan_nxt;
            init_cnt    <= init_nxt;
            busy        <= busy_nxt;
            mov_en      <= mov_en_nxt;
            sum_en      <= sum_en_nxt;
            game_won    <= won_nxt;
            game_lost   <= lost_nxt;
        end
    end

endmodule

// File: tb/tb_game_move_sequencer.sv
// tb_game_move_sequencer: scoreboard bench for game_move_sequencer.
// A responder answers mov_en/sum_en with a programmed board; each move pushes
// its expected outcome (pre-spawn board, spawn count, win/lose flags) and the
// entry is popped and compared when busy falls.
module tb_game_move_sequencer;

    typedef logic [3:0][3:0][11:0] board_t;

    typedef struct {
        board_t board;
        int     spawns;
        bit     won;
        bit     lost;
    } sb_entry_t;

    logic       clk;
    logic       rst;
    logic [3:0] dir;
    board_t     board;
    logic [3:0] move_dir;
    board_t     work_matrix;
    logic       mov_en;
    logic       mov_done;
    board_t     mov_result;
    logic       sum_en;
    logic       sum_ready;
    board_t     sum_result;
    logic       busy;
    logic       game_won;
    logic       game_lost;

    board_t     resp_board;
    board_t     model_board;
    bit         model_en;
    int         n_checks;
    int         n_fail;
    int         en_overlap;
    sb_entry_t  sb_q[$];

    game_move_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .dir         (dir),
        .board       (board),
        .move_dir    (move_dir),
        .work_matrix (work_matrix),
        .mov_en      (mov_en),
        .mov_done    (mov_done),
        .mov_result  (mov_result),
        .sum_en      (sum_en),
        .sum_ready   (sum_ready),
        .sum_result  (sum_result),
        .busy        (busy),
        .game_won    (game_won),
        .game_lost   (game_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath responder: answers a request on the same negedge it is seen
    initial begin
        mov_done   = 1'b0;
        sum_ready  = 1'b0;
        mov_result = '0;
        sum_result = '0;
        forever begin
            @(negedge clk);
            if (mov_en && sum_en) en_overlap++;
            mov_result = resp_board;
            sum_result = resp_board;
            mov_done   = model_en && mov_en;
            sum_ready  = model_en && sum_en;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int count_nonzero(input board_t b);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] != 12'd0) n++;
        return n;
    endfunction

    function automatic int count_diff(input board_t a, input board_t b);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (a[r][c] != b[r][c]) n++;
        return n;
    endfunction

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Pop the oldest expectation and compare it with the settled DUT state
    task automatic check_outcome(input string tag);
        sb_entry_t e;
        int ndiff;
        int nbad;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        ndiff = 0;
        nbad  = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board[r][c] != e.board[r][c]) begin
                    ndiff++;
                    if (e.board[r][c] != 12'd0 || board[r][c] != 12'd2) nbad++;
                end
            end
        end
        check_eq({tag, "_spawned"}, 32'(ndiff), 32'(e.spawns));
        check_eq({tag, "_bad_cells"}, 32'(nbad), 32'd0);
        check_eq({tag, "_won"}, 32'(game_won), 32'(e.won));
        check_eq({tag, "_lost"}, 32'(game_lost), 32'(e.lost));
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        model_board = board;
    endtask

    task automatic run_move(input string tag, input logic [3:0] d, input board_t resp,
                            input int spawns, input bit won, input bit lost);
        sb_entry_t e;
        bit ok;
        resp_board = resp;
        e.board  = resp;
        e.spawns = spawns;
        e.won    = won;
        e.lost   = lost;
        sb_q.push_back(e);
        @(negedge clk);
        dir = d;
        @(negedge clk);
        dir = 4'b0000;
        wait_idle(80, ok);
        check_eq({tag, "_done"}, 32'(ok), 32'd1);
        check_outcome(tag);
    endtask

    task automatic reset_and_init(input string tag);
        sb_entry_t e;
        bit ok;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        e.board  = '0;
        e.spawns = 2;
        e.won    = 1'b0;
        e.lost   = 1'b0;
        sb_q.push_back(e);
        rst = 1'b0;
        wait_idle(34, ok);
        check_eq({tag, "_init_done"}, 32'(ok), 32'd1);
        check_outcome(tag);
    endtask

    // Terminal states: further requests must be ignored
    task automatic check_terminal(input string tag, input bit won, input bit lost);
        @(negedge clk);
        dir = 4'b0001;
        repeat (4) begin
            @(negedge clk);
            check_eq({tag, "_mov_en"}, 32'(mov_en), 32'd0);
        end
        dir = 4'b0000;
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_won"}, 32'(game_won), 32'(won));
        check_eq({tag, "_lost"}, 32'(game_lost), 32'(lost));
        check_eq({tag, "_board"}, 32'(count_diff(board, model_board)), 32'd0);
    endtask

    initial begin
        board_t merged;
        board_t lose_b;
        board_t win_b;
        bit ok;

        n_checks   = 0;
        n_fail     = 0;
        en_overlap = 0;
        rst        = 1'b1;
        dir        = 4'b0000;
        model_en   = 1'b1;
        resp_board = '0;
        model_board = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_board", 32'(count_nonzero(board)), 32'd0);
        check_eq("rst_work", 32'(count_nonzero(work_matrix)), 32'd0);
        check_eq("rst_move_dir", 32'(move_dir), 32'd0);
        check_eq("rst_mov_en", 32'(mov_en), 32'd0);
        check_eq("rst_sum_en", 32'(sum_en), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_won", 32'(game_won), 32'd0);
        check_eq("rst_lost", 32'(game_lost), 32'd0);

        // Seeding after reset: exactly two 2-tiles
        begin
            sb_entry_t e;
            e.board  = '0;
            e.spawns = 2;
            e.won    = 1'b0;
            e.lost   = 1'b0;
            sb_q.push_back(e);
        end
        rst = 1'b0;
        wait_idle(34, ok);
        check_eq("init_done", 32'(ok), 32'd1);
        check_outcome("init");
        check_eq("init_tiles", 32'(count_nonzero(board)), 32'd2);

        // Multi-bit and zero requests are ignored
        dir = 4'b0011;
        repeat (3) begin
            @(negedge clk);
            check_eq("multibit_mov_en", 32'(mov_en), 32'd0);
        end
        dir = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            check_eq("zero_mov_en", 32'(mov_en), 32'd0);
        end
        check_eq("ignored_busy", 32'(busy), 32'd0);
        check_eq("ignored_board", 32'(count_diff(board, model_board)), 32'd0);

        // Datapaths return the current board: no commit, no spawn
        run_move("nochange", 4'b1000, model_board, 0, 1'b0, 1'b0);
        check_eq("nochange_move_dir", 32'(move_dir), 32'b1000);

        // Merged board with a single 4 at [3][0]: commit plus one new 2
        merged = '0;
        merged[3][0] = 12'd4;
        run_move("merge", 4'b0100, merged, 1, 1'b0, 1'b0);
        check_eq("merge_move_dir", 32'(move_dir), 32'b0100);
        check_eq("merge_tile", 32'(board[3][0]), 32'd4);
        check_eq("merge_tiles", 32'(count_nonzero(board)), 32'd2);

        // 2/4 checkerboard with one hole: spawn fills it and the game is lost
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                lose_b[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
        lose_b[0][0] = 12'd0;
        run_move("lose", 4'b1000, lose_b, 1, 1'b0, 1'b1);
        check_eq("lose_hole", 32'(board[0][0]), 32'd2);
        check_terminal("lose_hold", 1'b0, 1'b1);

        // Winning tile: game_won held, no spawn, later requests ignored
        reset_and_init("init2");
        win_b = '0;
        win_b[0][0] = 12'd2048;
        run_move("win", 4'b0010, win_b, 0, 1'b1, 1'b0);
        check_terminal("win_hold", 1'b1, 1'b0);

        // Reset while stalled in MOVE1 aborts the move
        reset_and_init("init3");
        model_en   = 1'b0;
        resp_board = '0;
        @(negedge clk);
        dir = 4'b0001;
        @(negedge clk);
        dir = 4'b0000;
        repeat (5) @(negedge clk);
        check_eq("stall_mov_en", 32'(mov_en), 32'd1);
        check_eq("stall_busy", 32'(busy), 32'd1);
        check_eq("stall_board", 32'(count_diff(board, model_board)), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("abort_board", 32'(count_nonzero(board)), 32'd0);
        check_eq("abort_mov_en", 32'(mov_en), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd1);
        model_en = 1'b1;
        reset_and_init("init4");

        check_eq("en_exclusive", 32'(en_overlap), 32'd0);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
